// File: rtl/pc_next_unit_pkg.sv
// ---------------------------------------------------------------------------
// mips_pc_pkg
// Purpose : shared definitions for the program-counter / next-PC unit of the
//           single-issue MIPS core.
// Contents: pc_state_e     - sequencing states of the PC unit (2-bit encoding)
//           PC_INCR        - sequential instruction step
//           JUMP_REGION_*  - bit range of PC+4 kept by a j/jal target
//           jump_target()  - forms the j/jal target from PC+4 and the index
// ---------------------------------------------------------------------------
package mips_pc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_HALT     = 2'd3
    } pc_state_e;

    localparam logic [31:0] PC_INCR         = 32'd4;
    localparam int          JUMP_REGION_MSB = 31;
    localparam int          JUMP_REGION_LSB = 28;

    // j/jal stay inside the current 256 MB region selected by PC+4.
    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [25:0] index);
        return {pc_plus4[JUMP_REGION_MSB:JUMP_REGION_LSB], index, 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_unit_if.sv
// ---------------------------------------------------------------------------
// pc_next_unit_if
// Purpose : bundles the control/redirect inputs and PC outputs of the PC unit.
// Modports: master - the pipeline side: drives stall/halt/redirect requests,
//                    observes pc, pc_plus4, flush, pc_valid, misalign_err
//           slave  - the PC unit itself (opposite directions)
// ---------------------------------------------------------------------------
interface pc_next_unit_if;

    logic        stall;
    logic        halt_req;
    logic        branch_en;
    logic        alu_zero;
    logic [31:0] branch_offset_x4;
    logic        jump_en;
    logic [25:0] jump_index;
    logic        jr_en;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        flush;
    logic        pc_valid;
    logic        misalign_err;

    modport master (
        output stall, halt_req, branch_en, alu_zero, branch_offset_x4,
               jump_en, jump_index, jr_en, jr_target,
        input  pc, pc_plus4, flush, pc_valid, misalign_err
    );

    modport slave (
        input  stall, halt_req, branch_en, alu_zero, branch_offset_x4,
               jump_en, jump_index, jr_en, jr_target,
        output pc, pc_plus4, flush, pc_valid, misalign_err
    );

endinterface

// File: rtl/pc_next_unit_adder_32.sv
// ---------------------------------------------------------------------------
// adder_32
// Purpose : 32-bit ripple-carry adder, result modulo 2^32 (carry-out dropped).
// Ports   : a, b - operands (32)
//           sum  - a + b, wrapping (32)
// ---------------------------------------------------------------------------
module adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    logic carry;

    always_comb begin
        carry = 1'b0;
        sum   = '0;
        for (int i = 0; i < 32; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// ---------------------------------------------------------------------------
// pc_next_unit
// Purpose : program-counter register and next-PC selection. Forms PC+4, the
//           beq target, the j/jal target and the jr target, registers the
//           winner, flags a one-cycle flush after every redirect and halts
//           (or word-aligns) on a misaligned jr target.
// Params  : RESET_VECTOR     - PC loaded by reset
//           HALT_ON_MISALIGN - 1: misaligned jr halts, 0: low bits cleared
// Ports   : clk   - rising-edge clock
//           rst_n - synchronous active-low reset
//           bus   - pc_next_unit_if.slave (stall, halt_req, branch_en,
//                   alu_zero, branch_offset_x4, jump_en, jump_index, jr_en,
//                   jr_target in; pc, pc_plus4, flush, pc_valid,
//                   misalign_err out)
// ---------------------------------------------------------------------------
module pc_next_unit
    import mips_pc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR     = 32'h0000_0000,
    parameter bit          HALT_ON_MISALIGN = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_next_unit_if.slave  bus
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic        pc_valid_q, pc_valid_d;
    logic        misalign_q, misalign_d;

    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jr_sel;
    logic [31:0] redirect_target;
    logic        redirect;
    logic        jr_misaligned;

    adder_32 u_add_pc4 (
        .a   (pc_q),
        .b   (PC_INCR),
        .sum (pc_plus4)
    );

    adder_32 u_add_branch (
        .a   (pc_plus4),
        .b   (bus.branch_offset_x4),
        .sum (branch_target)
    );

    // Target mux in priority order jr > j > beq. A not-taken beq is not a
    // redirect and simply falls through to PC+4.
    always_comb begin
        jr_misaligned   = (bus.jr_target[1:0] != 2'b00);
        jr_sel          = HALT_ON_MISALIGN ? bus.jr_target
                                           : {bus.jr_target[31:2], 2'b00};
        redirect        = bus.jr_en | bus.jump_en | (bus.branch_en & bus.alu_zero);
        redirect_target = branch_target;
        if (bus.jr_en)
            redirect_target = jr_sel;
        else if (bus.jump_en)
            redirect_target = jump_target(pc_plus4, bus.jump_index);
    end

    // Sequencing: stall freezes everything and drops requests; halt_req beats
    // any redirect; a misaligned jr either halts (pc untouched) or proceeds
    // with the aligned target, and in both cases sets the sticky error.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        flush_d    = 1'b0;
        pc_valid_d = pc_valid_q;
        misalign_d = misalign_q;
        case (state_q)
            ST_BOOT: begin
                state_d    = ST_RUN;
                pc_valid_d = 1'b1;
            end
            ST_RUN, ST_REDIRECT: begin
                if (!bus.stall) begin
                    if (bus.halt_req) begin
                        state_d    = ST_HALT;
                        pc_valid_d = 1'b0;
                    end else if (bus.jr_en && jr_misaligned && HALT_ON_MISALIGN) begin
                        state_d    = ST_HALT;
                        pc_valid_d = 1'b0;
                        misalign_d = 1'b1;
                    end else if (redirect) begin
                        state_d = ST_REDIRECT;
                        pc_d    = redirect_target;
                        flush_d = 1'b1;
                        if (bus.jr_en && jr_misaligned)
                            misalign_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        pc_d    = pc_plus4;
                    end
                end
            end
            ST_HALT: begin
                pc_valid_d = 1'b0;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            flush_q    <= 1'b0;
            pc_valid_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            flush_q    <= flush_d;
            pc_valid_q <= pc_valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pc_plus4     = pc_plus4;
    assign bus.flush        = flush_q;
    assign bus.pc_valid     = pc_valid_q;
    assign bus.misalign_err = misalign_q;

endmodule
